// File: rtl/key_shift_in.sv
// key_shift_in: periodic reader for a 74HC165-style PISO chain. It loads the chain,
// shifts WIDTH bits in MSB-first and debounces the word over consecutive scans.
module key_shift_in #(
  parameter int WIDTH       = 8,
  parameter int CLK_DIV     = 4,
  parameter int SCAN_PERIOD = 1000,
  parameter int DEB_CNT     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sft_q7,
  output logic             sft_pl,
  output logic             sft_cp,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             chg
);

  localparam int SCW = $clog2(SCAN_PERIOD + 1);
  localparam int PW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CP_HI, S_CP_LO, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [15:0]      div_cnt_q, div_cnt_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] raw_prev_q, raw_prev_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [3:0]       stab_q, stab_d;
  logic             pl_q, pl_d, cp_q, cp_d, vld_q, vld_d, chg_q, chg_d;

  logic       wrap, trig, phase_end, samp;
  logic [3:0] stab_new;

  assign wrap      = (scan_cnt_q == SCW'(SCAN_PERIOD - 1));
  assign trig      = wrap | start;
  assign phase_end = (div_cnt_q == 16'(CLK_DIV - 1));

  // Next-state logic: scan sequencer, shift register, debouncer and pin drivers.
  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    samp       = 1'b0;
    scan_cnt_d = wrap ? '0 : scan_cnt_q + 1'b1;
    case (state_q)
      S_IDLE:   if (trig) state_d = S_LOAD;
      S_LOAD:   if (phase_end) state_d = S_SETTLE;
      S_SETTLE: if (phase_end) begin
        samp    = 1'b1;
        pair_d  = '0;
        state_d = S_CP_HI;
      end
      S_CP_HI:  if (phase_end) state_d = S_CP_LO;
      S_CP_LO:  if (phase_end) begin
        samp = 1'b1;
        // WIDTH-1 high/low pairs follow the SETTLE sample
        if (pair_q == PW'(WIDTH - 2)) begin
          state_d = S_DONE;
        end else begin
          pair_d  = pair_q + 1'b1;
          state_d = S_CP_HI;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // phase counter restarts on every state change and idles at zero
    div_cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : div_cnt_q + 1'b1;
    shreg_d   = samp ? {shreg_q[WIDTH-2:0], sft_q7} : shreg_q;

    // debounce: stability count saturates at 15
    if (shreg_q == raw_prev_q) stab_new = (stab_q == 4'd15) ? 4'd15 : stab_q + 4'd1;
    else                       stab_new = 4'd1;

    stab_d     = stab_q;
    raw_prev_d = raw_prev_q;
    dout_d     = dout_q;
    vld_d      = 1'b0;
    chg_d      = 1'b0;
    if (state_q == S_DONE) begin
      stab_d     = stab_new;
      raw_prev_d = shreg_q;
      vld_d      = 1'b1;
      if (stab_new >= 4'(DEB_CNT) && shreg_q != dout_q) begin
        dout_d = shreg_q;
        chg_d  = 1'b1;
      end
    end

    // pins follow the next state so they change exactly with the state register
    pl_d = (state_d != S_LOAD);
    cp_d = (state_d == S_CP_HI);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      scan_cnt_q <= '0;
      div_cnt_q  <= '0;
      pair_q     <= '0;
      shreg_q    <= '0;
      raw_prev_q <= '0;
      dout_q     <= '0;
      stab_q     <= '0;
      pl_q       <= 1'b1;
      cp_q       <= 1'b0;
      vld_q      <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      div_cnt_q  <= div_cnt_d;
      pair_q     <= pair_d;
      shreg_q    <= shreg_d;
      raw_prev_q <= raw_prev_d;
      dout_q     <= dout_d;
      stab_q     <= stab_d;
      pl_q       <= pl_d;
      cp_q       <= cp_d;
      vld_q      <= vld_d;
      chg_q      <= chg_d;
    end
  end

  assign sft_pl   = pl_q;
  assign sft_cp   = cp_q;
  assign busy     = (state_q != S_IDLE);
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign chg      = chg_q;

endmodule

// File: tb/tb_key_shift_in.sv
// Bench for key_shift_in: three instances (8-bit DEB 1, 8-bit DEB 3, 16-bit fast)
// each fed by a behavioural 74HC165 chain model.
module tb_key_shift_in;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st[3];
  logic        pl[3], cp[3], bsy[3], vld[3], chgw[3];
  logic [31:0] par[3], chain[3];
  logic        cpp[3];
  logic [7:0]  d0, d1;
  logic [15:0] d2;
  logic [31:0] dw[3];
  logic        q7_0, q7_1, q7_2;

  int total = 0;
  int bad   = 0;

  assign dw[0] = {24'b0, d0};
  assign dw[1] = {24'b0, d1};
  assign dw[2] = {16'b0, d2};
  assign q7_0  = chain[0][7];
  assign q7_1  = chain[1][7];
  assign q7_2  = chain[2][15];

  key_shift_in #(.WIDTH(8), .CLK_DIV(4), .SCAN_PERIOD(1000), .DEB_CNT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sft_q7(q7_0), .sft_pl(pl[0]), .sft_cp(cp[0]),
    .busy(bsy[0]), .dout(d0), .dout_vld(vld[0]), .chg(chgw[0]));
  key_shift_in #(.WIDTH(8), .CLK_DIV(4), .SCAN_PERIOD(1000), .DEB_CNT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sft_q7(q7_1), .sft_pl(pl[1]), .sft_cp(cp[1]),
    .busy(bsy[1]), .dout(d1), .dout_vld(vld[1]), .chg(chgw[1]));
  key_shift_in #(.WIDTH(16), .CLK_DIV(1), .SCAN_PERIOD(1000), .DEB_CNT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sft_q7(q7_2), .sft_pl(pl[2]), .sft_cp(cp[2]),
    .busy(bsy[2]), .dout(d2), .dout_vld(vld[2]), .chg(chgw[2]));

  // 74HC165 model: PL low loads, rising CP shifts towards Q7
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!pl[i])               chain[i] <= par[i];
      else if (cp[i] && !cpp[i]) chain[i] <= chain[i] << 1;
      cpp[i] <= cp[i];
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse start on instance i and measure the scan until dout_vld (bounded).
  task automatic run_scan(input int i, output int pl_n, output int rise_n, output int busy_n,
                          output logic got, output logic [31:0] d, output logic c);
    logic prev;
    pl_n = 0; rise_n = 0; busy_n = 0; got = 1'b0; d = '0; c = 1'b0; prev = 1'b0;
    st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (!pl[i]) pl_n++;
      if (cp[i] && !prev) rise_n++;
      prev = cp[i];
      if (bsy[i]) busy_n++;
      if (vld[i]) begin
        got = 1'b1; d = dw[i]; c = chgw[i];
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    int vcnt;
    logic seen;
    do_reset();
    par[0] = 32'hA5;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (cp[0]) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_reach_cphi got=%0b want=1", seen); end
    rst_n = 1'b0;
    #1;
    total++; if (cp[0] !== 1'b0) begin bad++; $display("FAIL rst_cp got=%0b want=0", cp[0]); end
    total++; if (pl[0] !== 1'b1) begin bad++; $display("FAIL rst_pl got=%0b want=1", pl[0]); end
    total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", bsy[0]); end
    total++; if (dw[0] !== 32'h0) begin bad++; $display("FAIL rst_dout got=%0h want=0", dw[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int n = 1; n <= 1064; n++) begin
      @(posedge clk); #1;
      if (vld[0]) vcnt++;
    end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL rst_no_vld got=%0d want=0", vcnt); end
  endtask

  task automatic test_basic();
    int pn, rn, bn;
    logic g, c;
    logic [31:0] d;
    do_reset();
    par[0] = 32'hA5;
    run_scan(0, pn, rn, bn, g, d, c);
    total++; if (g !== 1'b1)   begin bad++; $display("FAIL a5_vld got=%0b want=1", g); end
    total++; if (pn !== 4)     begin bad++; $display("FAIL a5_pl_low got=%0d want=4", pn); end
    total++; if (rn !== 7)     begin bad++; $display("FAIL a5_cp_edges got=%0d want=7", rn); end
    total++; if (bn !== 65)    begin bad++; $display("FAIL a5_busy got=%0d want=65", bn); end
    total++; if (d !== 32'hA5) begin bad++; $display("FAIL a5_dout got=%0h want=a5", d); end
    total++; if (c !== 1'b1)   begin bad++; $display("FAIL a5_chg got=%0b want=1", c); end
  endtask

  task automatic test_debounce();
    logic [31:0] pat[6];
    logic        ec[6];
    logic [31:0] ed[6];
    int pn, rn, bn;
    logic g, c;
    logic [31:0] d;
    pat = '{32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3D, 32'h3C};
    ec  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ed  = '{32'h0, 32'h0, 32'h3C, 32'h3C, 32'h3C, 32'h3C};
    do_reset();
    for (int s = 0; s < 6; s++) begin
      par[1] = pat[s];
      run_scan(1, pn, rn, bn, g, d, c);
      total++; if (g !== 1'b1 || c !== ec[s])
        begin bad++; $display("FAIL deb_chg scan=%0d got=%0b vld=%0b want=%0b", s + 1, c, g, ec[s]); end
      total++; if (d !== ed[s])
        begin bad++; $display("FAIL deb_dout scan=%0d got=%0h want=%0h", s + 1, d, ed[s]); end
    end
  endtask

  task automatic test_periodic();
    int vcnt, first, second;
    do_reset();
    par[0] = 32'h5A;
    vcnt = 0; first = -1; second = -1;
    for (int n = 1; n <= 2070; n++) begin
      if (n == 1020) st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      if (vld[0]) begin
        vcnt++;
        if (first < 0) first = n; else if (second < 0) second = n;
      end
    end
    total++; if (first !== 1065) begin bad++; $display("FAIL per_first got=%0d want=1065", first); end
    total++; if (second - first !== 1000)
      begin bad++; $display("FAIL per_spacing got=%0d want=1000", second - first); end
    total++; if (vcnt !== 2) begin bad++; $display("FAIL per_count got=%0d want=2", vcnt); end
    total++; if (dw[0] !== 32'h5A) begin bad++; $display("FAIL per_dout got=%0h want=5a", dw[0]); end
  endtask

  task automatic test_simultaneous();
    int vcnt, first;
    do_reset();
    vcnt = 0; first = -1;
    for (int n = 1; n <= 1150; n++) begin
      @(posedge clk); #1;
      st[0] = (n == 999);
      if (vld[0]) begin
        vcnt++;
        if (first < 0) first = n;
      end
    end
    total++; if (vcnt !== 1)    begin bad++; $display("FAIL sim_count got=%0d want=1", vcnt); end
    total++; if (first !== 1065) begin bad++; $display("FAIL sim_at got=%0d want=1065", first); end
  endtask

  task automatic test_wide();
    int pn, rn, bn;
    logic g, c;
    logic [31:0] d;
    do_reset();
    par[2] = 32'h8001;
    run_scan(2, pn, rn, bn, g, d, c);
    total++; if (g !== 1'b1)     begin bad++; $display("FAIL w16_vld got=%0b want=1", g); end
    total++; if (rn !== 15)      begin bad++; $display("FAIL w16_cp_edges got=%0d want=15", rn); end
    total++; if (bn !== 33)      begin bad++; $display("FAIL w16_busy got=%0d want=33", bn); end
    total++; if (pn !== 1)       begin bad++; $display("FAIL w16_pl_low got=%0d want=1", pn); end
    total++; if (d !== 32'h8001) begin bad++; $display("FAIL w16_dout got=%0h want=8001", d); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; par[i] = '0; end
    test_reset();
    test_basic();
    test_debounce();
    test_periodic();
    test_simultaneous();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
